alu_cmd_sequencer: RTL and testbench

- Command-side front end for the 32-bit combinational ALU. Accepts operation commands over a valid/ready handshake and drives the ALU's A/B/sel/Cin inputs.
- Captures the ALU's Y/Cout/Negative/Zero/Overflow outputs and returns a registered result over a second valid/ready handshake.
- Supports 64-bit ADD/SUB by sequencing two ALU passes, with carry chained from the low word into the high word.
- Sits between the register-file/controller and the ALU.

---
 rtl/alu_cmd_sequencer_if.sv | 51 +++++
 rtl/alu_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-side and response signals of alu_cmd_sequencer, bundled for port use.
// slave = the sequencer itself; master = the controller/ALU environment around it.
interface alu_cmd_sequencer_if #(
    parameter int DW  = 32,
    parameter int OPW = 4
);
    // Command handshake from the controller
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OPW-1:0]    cmd_op;
    logic              cmd_wide;
    logic [2*DW-1:0]   cmd_a;
    logic [2*DW-1:0]   cmd_b;

    // Combinational ALU connection
    logic [DW-1:0]     alu_A;
    logic [DW-1:0]     alu_B;
    logic [OPW-1:0]    alu_sel;
    logic              alu_Cin;
    logic [DW-1:0]     alu_Y;
    logic              alu_Cout;
    logic              alu_Negative;
    logic              alu_Zero;
    logic              alu_Overflow;

    // Response handshake back to the controller
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*DW-1:0]   rsp_y;
    logic [3:0]        rsp_flags;
    logic              rsp_illegal;
    logic              chk_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b,
        input  alu_Y, alu_Cout, alu_Negative, alu_Zero, alu_Overflow,
        input  rsp_ready,
        output cmd_ready,
        output alu_A, alu_B, alu_sel, alu_Cin,
        output rsp_valid, rsp_y, rsp_flags, rsp_illegal, chk_err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b,
        output alu_Y, alu_Cout, alu_Negative, alu_Zero, alu_Overflow,
        output rsp_ready,
        input  cmd_ready,
        input  alu_A, alu_B, alu_sel, alu_Cin,
        input  rsp_valid, rsp_y, rsp_flags, rsp_illegal, chk_err
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the 32-bit combinational ALU; sequences 64-bit ADD/SUB as two chained passes.
// Optional ALU_SELF_CHECK_EN adds a behavioural ALU model that raises a sticky chk_err on any mismatch.
module alu_cmd_sequencer #(
    parameter int DW  = 32,
    parameter int OPW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_cmd_sequencer_if.slave    bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LO   = 2'd1;
    localparam logic [1:0] HI   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [OPW-1:0] OP_AND  = OPW'(0);
    localparam logic [OPW-1:0] OP_OR   = OPW'(1);
    localparam logic [OPW-1:0] OP_NOTA = OPW'(2);
    localparam logic [OPW-1:0] OP_NOR  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
    localparam logic [OPW-1:0] OP_NAND = OPW'(5);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(6);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(7);

    // Flag vector layout {N,Z,V,C}
    localparam int FLAG_Z = 2;
    localparam logic [3:0] ILLEGAL_FLAGS = 4'b0100;

    logic [1:0]       state;

    // Upper operand halves are the only part of the command still needed after accept;
    // the low halves go straight into the ALU drive registers.
    logic [DW-1:0]    a_hi;
    logic [DW-1:0]    b_hi;
    logic             wide_q;

    logic [DW-1:0]    alu_a_q;
    logic [DW-1:0]    alu_b_q;
    logic [OPW-1:0]   alu_sel_q;
    logic             alu_cin_q;

    logic [2*DW-1:0]  y_q;
    logic [3:0]       flags_q;
    logic             illegal_q;

    logic             cmd_legal;
    logic             cmd_arith;
    logic [3:0]       alu_flags;

    assign cmd_legal = (bus.cmd_op <= OP_SUB);
    assign cmd_arith = (bus.cmd_op == OP_ADD) || (bus.cmd_op == OP_SUB);
    assign alu_flags = {bus.alu_Negative, bus.alu_Zero, bus.alu_Overflow, bus.alu_Cout};

    // NOTE: state is updated with non-blocking assignments so every register in this
    // block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_hi      <= '0;
            b_hi      <= '0;
            wide_q    <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            alu_cin_q <= 1'b0;
            y_q       <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (cmd_legal) begin
                            alu_a_q   <= bus.cmd_a[DW-1:0];
                            alu_b_q   <= bus.cmd_b[DW-1:0];
                            alu_sel_q <= bus.cmd_op;
                            alu_cin_q <= (bus.cmd_op == OP_SUB);
                            a_hi      <= bus.cmd_a[2*DW-1:DW];
                            b_hi      <= bus.cmd_b[2*DW-1:DW];
                            // Logic ops ignore cmd_wide and the upper operand bits
                            wide_q    <= bus.cmd_wide & cmd_arith;
                            illegal_q <= 1'b0;
                            state     <= LO;
                        end else begin
                            // ALU drive is left untouched so it does not toggle
                            y_q       <= '0;
                            flags_q   <= ILLEGAL_FLAGS;
                            illegal_q <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end

                LO: begin
                    y_q     <= {{DW{1'b0}}, bus.alu_Y};
                    flags_q <= alu_flags;
                    if (wide_q) begin
                        alu_a_q   <= a_hi;
                        alu_b_q   <= b_hi;
                        alu_cin_q <= bus.alu_Cout;
                        state     <= HI;
                    end else begin
                        state <= RESP;
                    end
                end

                HI: begin
                    y_q[2*DW-1:DW] <= bus.alu_Y;
                    // flags_q[FLAG_Z] still holds the low-pass Zero here
                    flags_q <= {bus.alu_Negative, flags_q[FLAG_Z] & bus.alu_Zero,
                                bus.alu_Overflow, bus.alu_Cout};
                    state   <= RESP;
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_y       = y_q;
    assign bus.rsp_flags   = flags_q;
    assign bus.rsp_illegal = illegal_q;

    assign bus.alu_A   = alu_a_q;
    assign bus.alu_B   = alu_b_q;
    assign bus.alu_sel = alu_sel_q;
    assign bus.alu_Cin = alu_cin_q;

`ifdef ALU_SELF_CHECK_EN
    function automatic logic [DW-1:0] model_y(
        input logic [DW-1:0]  a,
        input logic [DW-1:0]  b,
        input logic [OPW-1:0] sel,
        input logic           cin
    );
        logic [DW-1:0] r;
        r = '0;
        case (sel)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOTA: r = ~a;
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_ADD:  r = a + b + DW'(cin);
            OP_SUB:  r = a + ~b + DW'(cin);
            default: r = '0;
        endcase
        return r;
    endfunction

    logic chk_err_q;

    // Only LO and HI present a meaningful ALU result; the flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else if ((state == LO || state == HI) &&
                     (bus.alu_Y != model_y(alu_a_q, alu_b_q, alu_sel_q, alu_cin_q))) begin
            chk_err_q <= 1'b1;
        end
    end

    assign bus.chk_err = chk_err_q;
`else
    assign bus.chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: vector table for single commands plus
// hand-written sequences for reset, HI-pass carry, backpressure, illegal op and mid-command reset.
module tb_alu_cmd_sequencer;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference 32-bit ALU: SUB computes A + ~B + Cin, logic ops report V=C=0.
    logic [32:0] alu_sum;
    logic [31:0] alu_bb;
    always_comb begin
        alu_sum          = '0;
        alu_bb           = bus.alu_B;
        bus.alu_Y        = '0;
        bus.alu_Cout     = 1'b0;
        bus.alu_Overflow = 1'b0;
        case (bus.alu_sel)
            4'd0: bus.alu_Y = bus.alu_A & bus.alu_B;
            4'd1: bus.alu_Y = bus.alu_A | bus.alu_B;
            4'd2: bus.alu_Y = ~bus.alu_A;
            4'd3: bus.alu_Y = ~(bus.alu_A | bus.alu_B);
            4'd4: bus.alu_Y = bus.alu_A ^ bus.alu_B;
            4'd5: bus.alu_Y = ~(bus.alu_A & bus.alu_B);
            4'd6, 4'd7: begin
                if (bus.alu_sel == 4'd7) alu_bb = ~bus.alu_B;
                alu_sum          = {1'b0, bus.alu_A} + {1'b0, alu_bb} + {32'd0, bus.alu_Cin};
                bus.alu_Y        = alu_sum[31:0];
                bus.alu_Cout     = alu_sum[32];
                bus.alu_Overflow = (bus.alu_A[31] == alu_bb[31]) && (alu_sum[31] != bus.alu_A[31]);
            end
            default: bus.alu_Y = '0;
        endcase
        bus.alu_Negative = bus.alu_Y[31];
        bus.alu_Zero     = (bus.alu_Y == 32'd0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for exactly one edge (the accept edge E) from IDLE.
    task automatic send(input logic [3:0] op, input logic wide,
                        input logic [63:0] a, input logic [63:0] b);
        bus.cmd_op    = op;
        bus.cmd_wide  = wide;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Counts edges after E until rsp_valid, bounded so a hung DUT still reaches the summary.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    task automatic complete_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        wide;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] y;
        logic [3:0]  flags;   // {N,Z,V,C}
        logic        illegal;
        int          lat;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        int   lat;
        logic [63:0] held_y;
        logic [3:0]  held_f;

        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_wide  = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;

        vecs[0]  = '{"and",       4'd0, 1'b0, 64'hF0F0F0F0, 64'hFF00FF00, 64'h00000000_F000F000, 4'b1000, 1'b0, 1};
        vecs[1]  = '{"or",        4'd1, 1'b0, 64'h000000FF, 64'hFF000000, 64'h00000000_FF0000FF, 4'b1000, 1'b0, 1};
        vecs[2]  = '{"nota_wide", 4'd2, 1'b1, 64'hDEADBEEF_FFFFFFFF, 64'h0, 64'h0, 4'b0100, 1'b0, 1};
        vecs[3]  = '{"nor",       4'd3, 1'b0, 64'h0, 64'h0, 64'h00000000_FFFFFFFF, 4'b1000, 1'b0, 1};
        vecs[4]  = '{"xor",       4'd4, 1'b0, 64'h0F0F0F0F, 64'h00FF00FF, 64'h00000000_0FF00FF0, 4'b0000, 1'b0, 1};
        vecs[5]  = '{"nand",      4'd5, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0, 4'b0100, 1'b0, 1};
        vecs[6]  = '{"add_ovf",   4'd6, 1'b0, 64'h11111111_7FFFFFFF, 64'h1, 64'h00000000_80000000, 4'b1010, 1'b0, 1};
        vecs[7]  = '{"add_carry", 4'd6, 1'b0, 64'hFFFFFFFF, 64'h1, 64'h0, 4'b0101, 1'b0, 1};
        vecs[8]  = '{"sub_pos",   4'd7, 1'b0, 64'h5, 64'h3, 64'h2, 4'b0001, 1'b0, 1};
        vecs[9]  = '{"sub_neg",   4'd7, 1'b0, 64'h3, 64'h5, 64'h00000000_FFFFFFFE, 4'b1000, 1'b0, 1};
        vecs[10] = '{"wadd",      4'd6, 1'b1, 64'h00000000_FFFFFFFF, 64'h1, 64'h00000001_00000000, 4'b0000, 1'b0, 2};
        vecs[11] = '{"wsub_m1",   4'd7, 1'b1, 64'h0, 64'h1, 64'hFFFFFFFF_FFFFFFFF, 4'b1000, 1'b0, 2};
        vecs[12] = '{"wsub_eq",   4'd7, 1'b1, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 64'h0, 4'b0101, 1'b0, 2};
        vecs[13] = '{"wadd_ovf",  4'd6, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 64'h80000000_00000000, 4'b1010, 1'b0, 2};
        vecs[14] = '{"wadd_zhi",  4'd6, 1'b1, 64'h1, 64'h0, 64'h1, 4'b0000, 1'b0, 2};
        vecs[15] = '{"illegal_f", 4'hF, 1'b1, 64'h5, 64'h5, 64'h0, 4'b0100, 1'b1, 0};

        // Reset state
        tick();
        check("rst cmd_ready",   64'(bus.cmd_ready), 64'd1);
        check("rst rsp_valid",   64'(bus.rsp_valid), 64'd0);
        check("rst rsp_y",       bus.rsp_y, 64'd0);
        check("rst rsp_flags",   64'(bus.rsp_flags), 64'd0);
        check("rst rsp_illegal", 64'(bus.rsp_illegal), 64'd0);
        check("rst chk_err",     64'(bus.chk_err), 64'd0);
        check("rst alu_drive",   {bus.alu_A, bus.alu_B}, 64'd0);
        check("rst alu_sel_cin", 64'({bus.alu_sel, bus.alu_Cin}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            check({vecs[i].name, " cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
            send(vecs[i].op, vecs[i].wide, vecs[i].a, vecs[i].b);
            wait_rsp(lat);
            check({vecs[i].name, " latency"}, 64'(lat), 64'(vecs[i].lat));
            check({vecs[i].name, " rsp_y"}, bus.rsp_y, vecs[i].y);
            check({vecs[i].name, " flags"}, 64'(bus.rsp_flags), 64'(vecs[i].flags));
            check({vecs[i].name, " illegal"}, 64'(bus.rsp_illegal), 64'(vecs[i].illegal));
            complete_rsp();
            check({vecs[i].name, " released"}, 64'({bus.rsp_valid, bus.cmd_ready}), 64'b01);
        end

        // Wide ADD: watch the ALU drive through LO and HI passes
        send(4'd6, 1'b1, 64'h00000000_FFFFFFFF, 64'h1);
        check("wadd lo drive", {bus.alu_A, bus.alu_B}, 64'hFFFFFFFF_00000001);
        check("wadd lo cin", 64'({bus.alu_sel, bus.alu_Cin, bus.cmd_ready}), 64'b0110_0_0);
        tick();
        check("wadd hi drive", {bus.alu_A, bus.alu_B}, 64'd0);
        check("wadd hi cin", 64'({bus.alu_Cin, bus.rsp_valid}), 64'b10);
        tick();
        check("wadd hi rsp", {63'd0, bus.rsp_valid} ^ bus.rsp_y, 64'h00000001_00000001);
        complete_rsp();

        // Backpressure: XOR response held for 3 cycles while the next command (OR) waits
        send(4'd4, 1'b0, 64'hAAAA0000, 64'h0000AAAA);
        bus.cmd_op    = 4'd1;
        bus.cmd_a     = 64'h1;
        bus.cmd_b     = 64'h4;
        bus.cmd_valid = 1'b1;
        tick();
        check("bp first valid", 64'(bus.rsp_valid), 64'd1);
        held_y = bus.rsp_y;
        held_f = bus.rsp_flags;
        check("bp xor y", held_y, 64'h00000000_AAAAAAAA);
        check("bp xor flags", 64'(held_f), 64'b1000);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("bp stall", {bus.rsp_y[59:0], held_f ^ bus.rsp_flags},
                  {held_y[59:0], 4'b0000});
            check("bp stall ready", 64'({bus.rsp_valid, bus.cmd_ready}), 64'b10);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("bp done idle", 64'({bus.rsp_valid, bus.cmd_ready}), 64'b01);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp next accepted", 64'({bus.cmd_ready, bus.alu_sel}), 64'b0_0001);
        wait_rsp(lat);
        check("bp next latency", 64'(lat), 64'd1);
        check("bp next y", bus.rsp_y, 64'h5);
        complete_rsp();

        // Illegal op leaves the ALU drive from the previous OR untouched
        send(4'b1010, 1'b0, 64'hFFFF, 64'hFFFF);
        check("ill valid at E", 64'({bus.rsp_valid, bus.rsp_illegal}), 64'b11);
        check("ill y", bus.rsp_y, 64'd0);
        check("ill flags", 64'(bus.rsp_flags), 64'b0100);
        check("ill alu_sel held", 64'({bus.alu_sel, bus.alu_A}), {28'd0, 4'd1, 32'h1});
        complete_rsp();

        // Reset pulsed during the HI pass of a wide ADD
        send(4'd6, 1'b1, 64'h5_00000001, 64'h6_00000001);
        tick();
        check("mid hi alu_A", 64'(bus.alu_A), 64'h5);
        rst_n = 1'b0;
        #1;
        check("mid rst async", 64'({bus.rsp_valid, bus.cmd_ready, bus.alu_A}), {30'd0, 2'b01, 32'd0});
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("mid rst no rsp", 64'({bus.rsp_valid, bus.cmd_ready}), 64'b01);
        send(4'd1, 1'b0, 64'h1, 64'h2);
        wait_rsp(lat);
        check("post rst latency", 64'(lat), 64'd1);
        check("post rst or", bus.rsp_y, 64'h3);
        check("post rst flags", 64'(bus.rsp_flags), 64'b0000);
        complete_rsp();

        check("chk_err clear", 64'(bus.chk_err), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
